// File: rtl/rv_core_pkg.sv
// Shared RV32 core definitions: register-file geometry, register index type,
// the register-file write-port payload and a one-hot decode helper.
package rv_core_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned XLEN       = 32;
    localparam int unsigned NUM_REGS   = 32;

    typedef logic [REG_ADDR_W-1:0] reg_idx_t;

    // One register-file write-port transaction
    typedef struct packed {
        logic            en;
        reg_idx_t        rd;
        logic [XLEN-1:0] data;
    } rf_wr_t;

    function automatic logic [NUM_REGS-1:0] reg_onehot(input reg_idx_t idx);
        return NUM_REGS'(1) << idx;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Long-latency destination scoreboard: busy vector, in-flight counter and
// the RAW/WAW/capacity hazard compare against the issuing instruction.
// Ports:
//   clk_i, rst_i                      clock, async active-high reset
//   iss_acc                           issue accepted this cycle
//   iss_rs1/iss_rs2/iss_rd            issuing instruction register indices
//   iss_rd_we, iss_long               writes rd / goes to a long unit
//   lng_commit, lng_rd                long result written this cycle
//   hazard                            combinational RAW|WAW|capacity
//   busy, outstanding                 registered scoreboard state
module rf_scoreboard
    import rv_core_pkg::*;
#(
    parameter int unsigned MAX_LONG = 4,
    localparam int unsigned CNT_W   = $clog2(MAX_LONG + 1)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                iss_acc,
    input  reg_idx_t            iss_rs1,
    input  reg_idx_t            iss_rs2,
    input  reg_idx_t            iss_rd,
    input  logic                iss_rd_we,
    input  logic                iss_long,
    input  logic                lng_commit,
    input  reg_idx_t            lng_rd,
    output logic                hazard,
    output logic [NUM_REGS-1:0] busy,
    output logic [CNT_W-1:0]    outstanding
);

    logic [NUM_REGS-1:0] busy_q, busy_d, clr_mask, set_mask, eff_busy;
    logic [CNT_W-1:0]    outstanding_q, outstanding_d;
    logic                long_acc, raw, waw, cap;

    // Hazard compare uses the busy view with this cycle's commit already cleared
    always_comb begin
        clr_mask = lng_commit ? reg_onehot(lng_rd) : '0;
        eff_busy = busy_q & ~clr_mask;
        long_acc = iss_acc & iss_long & iss_rd_we;
        set_mask = (long_acc && iss_rd != '0) ? reg_onehot(iss_rd) : '0;

        raw = eff_busy[iss_rs1] | eff_busy[iss_rs2];
        waw = iss_rd_we & eff_busy[iss_rd];
        // A same-cycle commit always frees a slot, so only a full, non-draining table blocks
        cap = iss_long & iss_rd_we & ~lng_commit & (outstanding_q == CNT_W'(MAX_LONG));
        hazard = raw | waw | cap;

        // Set is applied after clear so it wins on the same register; x0 never tracked
        busy_d = ((busy_q & ~clr_mask) | set_mask) & ~NUM_REGS'(1);

        outstanding_d = outstanding_q;
        case ({long_acc, lng_commit})
            2'b10:   outstanding_d = outstanding_q + CNT_W'(1);
            2'b01:   if (outstanding_q != '0) outstanding_d = outstanding_q - CNT_W'(1);
            default: outstanding_d = outstanding_q;
        endcase
    end

    // Scoreboard state
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            busy_q        <= '0;
            outstanding_q <= '0;
        end else begin
            busy_q        <= busy_d;
            outstanding_q <= outstanding_d;
        end
    end

    assign busy        = busy_q;
    assign outstanding = outstanding_q;

    // A long result must target a register it actually reserved (x0 is never reserved)
    a_commit_busy: assert property (@(posedge clk_i) disable iff (rst_i)
        (lng_commit && lng_rd != '0) |-> busy_q[lng_rd]);

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Register-file write-port scheduler: shares the single RF write port between
// the single-cycle writeback (absolute priority) and long-latency results,
// stalls issue on scoreboard hazards and on long-result starvation.
// Optional macro RF_SCHED_PERF_EN adds stall_cycles_o / starve_events_o.
// Ports:
//   clk_i, rst_i                                   clock, async active-high reset
//   iss_valid_i, iss_rs1_i, iss_rs2_i, iss_rd_i,
//   iss_rd_we_i, iss_long_i                        issuing instruction
//   iss_stall_o                                    hold issue this cycle
//   pipe_wb_en_i, pipe_wb_rd_i, pipe_wb_data_i     single-cycle writeback
//   lng_valid_i, lng_rd_i, lng_data_i, lng_ready_o long-latency result handshake
//   rf_wr_en_o, rf_wr_reg_o, rf_wr_data_o          register-file write port
//   busy_o, outstanding_o                          scoreboard state
//   stall_cycles_o, starve_events_o                perf counters (macro only)
module regfile_wb_scheduler
    import rv_core_pkg::*;
#(
    parameter int unsigned MAX_LONG     = 4,
    parameter int unsigned STARVE_LIMIT = 8,
    localparam int unsigned CNT_W       = $clog2(MAX_LONG + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  iss_valid_i,
    input  logic [REG_ADDR_W-1:0] iss_rs1_i,
    input  logic [REG_ADDR_W-1:0] iss_rs2_i,
    input  logic [REG_ADDR_W-1:0] iss_rd_i,
    input  logic                  iss_rd_we_i,
    input  logic                  iss_long_i,
    output logic                  iss_stall_o,
    input  logic                  pipe_wb_en_i,
    input  logic [REG_ADDR_W-1:0] pipe_wb_rd_i,
    input  logic [XLEN-1:0]       pipe_wb_data_i,
    input  logic                  lng_valid_i,
    input  logic [REG_ADDR_W-1:0] lng_rd_i,
    input  logic [XLEN-1:0]       lng_data_i,
    output logic                  lng_ready_o,
    output logic                  rf_wr_en_o,
    output logic [REG_ADDR_W-1:0] rf_wr_reg_o,
    output logic [XLEN-1:0]       rf_wr_data_o,
    output logic [NUM_REGS-1:0]   busy_o,
    output logic [CNT_W-1:0]      outstanding_o
`ifdef RF_SCHED_PERF_EN
    ,
    output logic [31:0]           stall_cycles_o,
    output logic [31:0]           starve_events_o
`endif
);

    localparam int unsigned SCNT_W = $clog2(STARVE_LIMIT + 1);

    rf_wr_t            wr_sel;
    logic              lng_commit, iss_acc, hazard, refused;
    logic [SCNT_W-1:0] starve_cnt_q, starve_cnt_d;
    logic              starve_flag_q, starve_flag_d;

    // Write-port mux: the pipeline cannot stall, so it always wins
    always_comb begin
        wr_sel = '0;
        if (pipe_wb_en_i) begin
            wr_sel = '{en: 1'b1, rd: pipe_wb_rd_i, data: pipe_wb_data_i};
        end else if (lng_valid_i) begin
            wr_sel = '{en: 1'b1, rd: lng_rd_i, data: lng_data_i};
        end
    end

    assign lng_ready_o  = ~pipe_wb_en_i;
    assign lng_commit   = lng_valid_i & lng_ready_o;
    assign refused      = lng_valid_i & ~lng_ready_o;
    assign rf_wr_en_o   = wr_sel.en;
    assign rf_wr_reg_o  = wr_sel.rd;
    assign rf_wr_data_o = wr_sel.data;

    assign iss_stall_o = iss_valid_i & (hazard | starve_flag_q);
    assign iss_acc     = iss_valid_i & ~iss_stall_o;

    rf_scoreboard #(.MAX_LONG(MAX_LONG)) u_sb (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .iss_acc     (iss_acc),
        .iss_rs1     (iss_rs1_i),
        .iss_rs2     (iss_rs2_i),
        .iss_rd      (iss_rd_i),
        .iss_rd_we   (iss_rd_we_i),
        .iss_long    (iss_long_i),
        .lng_commit  (lng_commit),
        .lng_rd      (lng_rd_i),
        .hazard      (hazard),
        .busy        (busy_o),
        .outstanding (outstanding_o)
    );

    // Starvation: count consecutive refusals; the flag is sticky until a commit
    always_comb begin
        starve_cnt_d  = starve_cnt_q;
        starve_flag_d = starve_flag_q;
        if (!refused) begin
            starve_cnt_d = '0;
        end else if (starve_cnt_q != SCNT_W'(STARVE_LIMIT)) begin
            starve_cnt_d = starve_cnt_q + SCNT_W'(1);
        end
        if (lng_commit) begin
            starve_flag_d = 1'b0;
        end else if (starve_cnt_d == SCNT_W'(STARVE_LIMIT)) begin
            starve_flag_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            starve_cnt_q  <= '0;
            starve_flag_q <= 1'b0;
        end else begin
            starve_cnt_q  <= starve_cnt_d;
            starve_flag_q <= starve_flag_d;
        end
    end

`ifdef RF_SCHED_PERF_EN
    // Saturating event counters
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cycles_o  <= '0;
            starve_events_o <= '0;
        end else begin
            if (iss_stall_o && stall_cycles_o != '1) begin
                stall_cycles_o <= stall_cycles_o + 32'd1;
            end
            if (!starve_flag_q && starve_flag_d && starve_events_o != '1) begin
                starve_events_o <= starve_events_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed bench for regfile_wb_scheduler: the driver pushes a hand-computed
// expectation per cycle, a negedge monitor pops and compares it.
module tb_regfile_wb_scheduler;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        iss_valid_i = 1'b0;
    logic [4:0]  iss_rs1_i = '0, iss_rs2_i = '0, iss_rd_i = '0;
    logic        iss_rd_we_i = 1'b0, iss_long_i = 1'b0;
    logic        iss_stall_o;
    logic        pipe_wb_en_i = 1'b0;
    logic [4:0]  pipe_wb_rd_i = '0;
    logic [31:0] pipe_wb_data_i = '0;
    logic        lng_valid_i = 1'b0;
    logic [4:0]  lng_rd_i = '0;
    logic [31:0] lng_data_i = '0;
    logic        lng_ready_o;
    logic        rf_wr_en_o;
    logic [4:0]  rf_wr_reg_o;
    logic [31:0] rf_wr_data_o;
    logic [31:0] busy_o;
    logic [2:0]  outstanding_o;
`ifdef RF_SCHED_PERF_EN
    logic [31:0] stall_cycles_o, starve_events_o;
`endif

    regfile_wb_scheduler #(.MAX_LONG(4), .STARVE_LIMIT(8)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .iss_valid_i    (iss_valid_i),
        .iss_rs1_i      (iss_rs1_i),
        .iss_rs2_i      (iss_rs2_i),
        .iss_rd_i       (iss_rd_i),
        .iss_rd_we_i    (iss_rd_we_i),
        .iss_long_i     (iss_long_i),
        .iss_stall_o    (iss_stall_o),
        .pipe_wb_en_i   (pipe_wb_en_i),
        .pipe_wb_rd_i   (pipe_wb_rd_i),
        .pipe_wb_data_i (pipe_wb_data_i),
        .lng_valid_i    (lng_valid_i),
        .lng_rd_i       (lng_rd_i),
        .lng_data_i     (lng_data_i),
        .lng_ready_o    (lng_ready_o),
        .rf_wr_en_o     (rf_wr_en_o),
        .rf_wr_reg_o    (rf_wr_reg_o),
        .rf_wr_data_o   (rf_wr_data_o),
        .busy_o         (busy_o),
        .outstanding_o  (outstanding_o)
`ifdef RF_SCHED_PERF_EN
        ,
        .stall_cycles_o (stall_cycles_o),
        .starve_events_o(starve_events_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        string       tag;
        logic        stall;
        logic        ready;
        logic        wen;
        logic [4:0]  wreg;
        logic [31:0] wdata;
        logic [31:0] busy;
        logic [2:0]  outs;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string tag, input string what, input logic [31:0] act,
                       input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s %s: got 0x%08h expected 0x%08h", tag, what, act, req);
        end
    endtask

    // Monitor: compare every presented cycle against the queued expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_i);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk(e.tag, "stall", 32'(iss_stall_o), 32'(e.stall));
                chk(e.tag, "lng_ready", 32'(lng_ready_o), 32'(e.ready));
                chk(e.tag, "wr_en", 32'(rf_wr_en_o), 32'(e.wen));
                chk(e.tag, "wr_reg", 32'(rf_wr_reg_o), 32'(e.wreg));
                chk(e.tag, "wr_data", rf_wr_data_o, e.wdata);
                chk(e.tag, "busy", busy_o, e.busy);
                chk(e.tag, "outstanding", 32'(outstanding_o), 32'(e.outs));
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        iss_valid_i = 1'b0; iss_rs1_i = '0; iss_rs2_i = '0; iss_rd_i = '0;
        iss_rd_we_i = 1'b0; iss_long_i = 1'b0;
        pipe_wb_en_i = 1'b0; pipe_wb_rd_i = '0; pipe_wb_data_i = '0;
        lng_valid_i = 1'b0; lng_rd_i = '0; lng_data_i = '0;
    endtask

    task automatic iss(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic we, input logic lng);
        iss_valid_i = 1'b1; iss_rs1_i = rs1; iss_rs2_i = rs2; iss_rd_i = rd;
        iss_rd_we_i = we; iss_long_i = lng;
    endtask

    task automatic pipe(input logic [4:0] rd, input logic [31:0] d);
        pipe_wb_en_i = 1'b1; pipe_wb_rd_i = rd; pipe_wb_data_i = d;
    endtask

    task automatic lng(input logic [4:0] rd, input logic [31:0] d);
        lng_valid_i = 1'b1; lng_rd_i = rd; lng_data_i = d;
    endtask

    task automatic expect_c(input string tag, input logic st, input logic rdy, input logic wen,
                            input logic [4:0] wr, input logic [31:0] wd,
                            input logic [31:0] bsy, input logic [2:0] o);
        exp_t e;
        e.tag = tag; e.stall = st; e.ready = rdy; e.wen = wen; e.wreg = wr;
        e.wdata = wd; e.busy = bsy; e.outs = o;
        exp_q.push_back(e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        idle();
        // Reset state, with and without a pipeline write
        tick(); idle(); expect_c("rst_idle", 0, 1, 0, 0, 0, 0, 0);
        tick(); idle(); pipe(5'd3, 32'hAAAA_0003);
        expect_c("rst_pipe", 0, 0, 1, 5'd3, 32'hAAAA_0003, 0, 0);
        tick(); idle(); rst_i = 1'b0; expect_c("post_rst", 0, 1, 0, 0, 0, 0, 0);

        // RAW stall then same-cycle commit bypass
        tick(); idle(); iss(0, 0, 5'd5, 1, 1); expect_c("long_x5", 0, 1, 0, 0, 0, 0, 0);
        tick(); idle(); iss(5'd5, 0, 5'd6, 1, 0);
        expect_c("raw_x5", 1, 1, 0, 0, 0, 32'h20, 1);
        tick(); idle(); iss(5'd5, 0, 5'd6, 1, 0); lng(5'd5, 32'hDEAD_0005);
        expect_c("bypass_x5", 0, 1, 1, 5'd5, 32'hDEAD_0005, 32'h20, 1);
        tick(); idle(); expect_c("x5_clear", 0, 1, 0, 0, 0, 0, 0);

        // Port conflict: pipe wins, long result waits
        tick(); idle(); iss(0, 0, 5'd7, 1, 1); expect_c("long_x7", 0, 1, 0, 0, 0, 0, 0);
        tick(); idle(); pipe(5'd3, 32'h0000_0033); lng(5'd7, 32'h0000_0077);
        expect_c("conflict", 0, 0, 1, 5'd3, 32'h0000_0033, 32'h80, 1);
        tick(); idle(); lng(5'd7, 32'h0000_0077);
        expect_c("late_x7", 0, 1, 1, 5'd7, 32'h0000_0077, 32'h80, 1);
        tick(); idle(); expect_c("x7_clear", 0, 1, 0, 0, 0, 0, 0);

        // Capacity: four in flight, fifth stalls unless a commit frees a slot
        tick(); idle(); iss(0, 0, 5'd1, 1, 1); expect_c("cap1", 0, 1, 0, 0, 0, 32'h0, 0);
        tick(); idle(); iss(0, 0, 5'd2, 1, 1); expect_c("cap2", 0, 1, 0, 0, 0, 32'h2, 1);
        tick(); idle(); iss(0, 0, 5'd3, 1, 1); expect_c("cap3", 0, 1, 0, 0, 0, 32'h6, 2);
        tick(); idle(); iss(0, 0, 5'd4, 1, 1); expect_c("cap4", 0, 1, 0, 0, 0, 32'hE, 3);
        tick(); idle(); iss(0, 0, 5'd8, 1, 1); expect_c("cap_full", 1, 1, 0, 0, 0, 32'h1E, 4);
        tick(); idle(); iss(0, 0, 5'd8, 1, 1); lng(5'd1, 32'h1111_0001);
        expect_c("cap_commit", 0, 1, 1, 5'd1, 32'h1111_0001, 32'h1E, 4);
        tick(); idle(); expect_c("cap_hold", 0, 1, 0, 0, 0, 32'h11C, 4);

        // Starvation: eight refused cycles set the flag and freeze issue
        for (int k = 0; k < 8; k++) begin
            tick(); idle(); iss(5'd10, 5'd11, 5'd12, 1, 0);
            pipe(5'd20, 32'h1000_0000 + 32'(k)); lng(5'd2, 32'h2222_0002);
            expect_c($sformatf("starve_c%0d", k + 1), 0, 0, 1, 5'd20,
                     32'h1000_0000 + 32'(k), 32'h11C, 4);
        end
        tick(); idle(); iss(5'd10, 5'd11, 5'd12, 1, 0);
        pipe(5'd20, 32'h1000_0008); lng(5'd2, 32'h2222_0002);
        expect_c("starve_frozen", 1, 0, 1, 5'd20, 32'h1000_0008, 32'h11C, 4);
        tick(); idle(); iss(5'd10, 5'd11, 5'd12, 1, 0); lng(5'd2, 32'h2222_0002);
        expect_c("starve_commit", 1, 1, 1, 5'd2, 32'h2222_0002, 32'h11C, 4);
        tick(); idle(); iss(5'd10, 5'd11, 5'd12, 1, 0);
        expect_c("starve_clear", 0, 1, 0, 0, 0, 32'h118, 3);

        // x0 is never tracked
        tick(); idle(); iss(0, 0, 5'd0, 1, 1); expect_c("long_x0", 0, 1, 0, 0, 0, 32'h118, 3);
        tick(); idle(); iss(0, 0, 5'd0, 1, 0); expect_c("use_x0", 0, 1, 0, 0, 0, 32'h118, 4);
        tick(); idle(); lng(5'd0, 32'h0000_00F0);
        expect_c("ret_x0", 0, 1, 1, 5'd0, 32'h0000_00F0, 32'h118, 4);

        // WAW
        tick(); idle(); iss(0, 0, 5'd9, 1, 1); expect_c("long_x9", 0, 1, 0, 0, 0, 32'h118, 3);
        tick(); idle(); iss(0, 0, 5'd9, 1, 0); expect_c("waw_x9", 1, 1, 0, 0, 0, 32'h318, 4);

        // Build busy = 0x0F00, then reset mid-flight
        tick(); idle(); iss(0, 0, 5'd10, 1, 1); lng(5'd3, 32'h3333_0003);
        expect_c("swap_x3", 0, 1, 1, 5'd3, 32'h3333_0003, 32'h318, 4);
        tick(); idle(); iss(0, 0, 5'd11, 1, 1); lng(5'd4, 32'h4444_0004);
        expect_c("swap_x4", 0, 1, 1, 5'd4, 32'h4444_0004, 32'h710, 4);
        tick(); idle(); expect_c("busy_f00", 0, 1, 0, 0, 0, 32'hF00, 4);
        tick(); idle(); rst_i = 1'b1; iss(5'd8, 0, 0, 0, 0);
        expect_c("mid_rst", 0, 1, 0, 0, 0, 0, 0);
        tick(); idle(); rst_i = 1'b0; iss(5'd8, 0, 0, 0, 0);
        expect_c("after_rst", 0, 1, 0, 0, 0, 0, 0);

        tick(); idle();
        for (int w = 0; w < 4 && exp_q.size() != 0; w++) @(negedge clk_i);
        if (exp_q.size() != 0) begin
            bad++;
            total++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        #2;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_wb_scheduler.md
# regfile_wb_scheduler

Register-file write-port scheduler and long-latency scoreboard for the RV32 core. It sits between decode/issue, the single-cycle writeback stage and the multi-cycle (load-miss/mul/div) result return, in front of the 32x32 register file. It shares the register file's one write port between the two writeback sources. It tracks destination registers of in-flight long-latency ops and stalls issue on RAW/WAW hazards, capacity limits and writeback starvation.

## Interface
- MAX_LONG, 4: maximum outstanding long-latency ops (1..31)
- STARVE_LIMIT, 8: consecutive cycles a long result may be refused before issue is frozen
- clk_i  in  1  clock, all state updates on rising edge
- rst_i  in  1  reset, asynchronous, active-high
- iss_valid_i  in  1  instruction at issue
- iss_rs1_i / iss_rs2_i  in  5  source registers
- iss_rd_i  in  5  destination register
- iss_rd_we_i  in  1  instruction writes rd
- iss_long_i  in  1  instruction goes to a long-latency unit
- iss_stall_o  out  1  hold issue this cycle
- pipe_wb_en_i / pipe_wb_rd_i / pipe_wb_data_i  in  1/5/32  single-cycle writeback
- lng_valid_i / lng_rd_i / lng_data_i  in  1/5/32  long-latency result
- lng_ready_o  out  1  long result accepted this cycle
- rf_wr_en_o / rf_wr_reg_o / rf_wr_data_o  out  1/5/32  register-file write port
- busy_o  out  32  scoreboard busy vector, bit 0 always 0
- outstanding_o  out  $clog2(MAX_LONG+1)  long ops in flight

## Operation
- iss_acc = iss_valid_i & ~iss_stall_o; lng_commit = lng_valid_i & lng_ready_o.
- Write port: pipe_wb_en_i has absolute priority (pipeline cannot stall). Otherwise lng_valid_i drives the port. Otherwise rf_wr_en_o=0, reg=0, data=0. lng_ready_o = ~pipe_wb_en_i. Combinational, zero latency.
- Scoreboard effective view: eff_busy = busy & ~(lng_commit ? onehot(lng_rd_i) : 0), which gives same-cycle clear bypass.
- iss_stall_o = iss_valid_i & (any of):
  - RAW: eff_busy[rs1] or eff_busy[rs2]
  - WAW: iss_rd_we_i & eff_busy[rd]
  - capacity: iss_long_i & iss_rd_we_i & (outstanding − lng_commit == MAX_LONG)
  - starvation: starve flag set
- Register x0 is never busy. Index 0 never stalls and never sets a busy bit.
- Busy set on iss_acc & iss_long_i & iss_rd_we_i & rd≠0; clear on lng_commit. Same-register set and clear in one cycle: set wins.
- outstanding: +1 on long issue acceptance, −1 on lng_commit, both → unchanged. It never wraps; the capacity stall guarantees this.
- Starvation counter: increments while lng_valid_i & ~lng_ready_o. Clears on lng_commit or when lng_valid_i is low. At STARVE_LIMIT it sets the starve flag (sticky), which freezes issue until lng_commit; the drained pipeline then frees the port.
- A lng_commit to a non-busy rd is a protocol error: the write still happens, the counter decrements, and a simulation assertion fires.

## Timing
- Reset: busy=0, outstanding=0, starve counter=0, flag=0. All outputs take the combinational value of that state: iss_stall_o=0, lng_ready_o=~pipe_wb_en_i, rf_wr_*=0 when no source is valid.
- Stall is combinational from registered state plus current inputs. There is no added latency.
- A busy bit set at edge N is visible to issue in cycle N+1. A cleared bit is visible in the commit cycle itself via the bypass.
- Reset mid-operation drops all tracking. The long units must be reset by the same rst_i.

## Configuration
- RF_SCHED_PERF_EN defined: adds 32-bit saturating counters stall_cycles_o (cycles with iss_stall_o=1) and starve_events_o (0→1 transitions of the starve flag). Both reset to 0.
- Undefined: the ports and counters are absent. All other behaviour is identical.

## Structure
- Shared package rv_core_pkg: REG_ADDR_W=5, XLEN=32, NUM_REGS=32, and the reg-index type.
- One sub-module, rf_scoreboard: busy vector, outstanding counter and the hazard compare. The port mux and starvation logic live in the top.

## Test plan
- Long issue rd=5, next cycle iss rs1=5 → stall. Then lng_valid rd=5, no pipe write → same-cycle commit, write x5, stall drops that cycle.
- pipe_wb_en=1 rd=3 and lng_valid rd=7 together → port writes x3, lng_ready_o=0. Next idle cycle writes x7.
- Four long issues to x1..x4 with MAX_LONG=4 → fifth long issue stalls. A commit in the same cycle allows it; outstanding_o stays 4.
- pipe_wb_en held high 8 cycles with lng_valid → starve flag at cycle 8, issue frozen. Pipe drops → commit, flag clears.
- Long issue rd=0 → busy_o stays 0, no stalls. WAW: long rd=9 pending, short issue rd=9 → stall.
- Reset asserted mid-flight with busy=0x0000_0F00 → busy_o=0, outstanding_o=0, stall_o=0 immediately.
